// File: rtl/mon_prod_radix.sv
// Radix-2^DIGIT Montgomery multiplier: P = A*B*2^(-DIGIT*num_digits) mod M.
// Iterates ADD_A / ADD_M per digit of B, then a final conditional subtraction.
module mon_prod_radix #(
    parameter int WIDTH = 1024,
    parameter int DIGIT = 1,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] M,
    input  logic [DIGIT-1:0] m_prime,
    input  logic [CNT_W-1:0] num_digits,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] P
);
    localparam int SW = WIDTH + DIGIT + 2;

    typedef enum logic [1:0] {IDLE, ADD_A, ADD_M, SUB} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] m_reg, m_next;
    logic [DIGIT-1:0] mp_reg, mp_next;
    logic [SW-1:0]    s_reg, s_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] p_reg, p_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic [SW-1:0]    a_ext, m_ext;
    logic [DIGIT-1:0] q;
    logic [SW-1:0]    a_sum [DIGIT+1];
    logic [SW-1:0]    m_sum [DIGIT+1];
    logic [SW-1:0]    s_reduced;
    logic             s_ge_m;

    assign a_ext = {{(SW-WIDTH){1'b0}}, a_reg};
    assign m_ext = {{(SW-WIDTH){1'b0}}, m_reg};
    assign q     = DIGIT'(s_reg[DIGIT-1:0] * mp_reg);

    // Shift-add chains: S + Areg*b and S + Mreg*q, one partial product per digit bit
    assign a_sum[0] = s_reg;
    assign m_sum[0] = s_reg;
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_pp
            assign a_sum[gi+1] = a_sum[gi] + (b_reg[gi] ? (a_ext << gi) : '0);
            assign m_sum[gi+1] = m_sum[gi] + (q[gi]     ? (m_ext << gi) : '0);
        end
    endgenerate

    // Low DIGIT bits of m_sum are zero, so the shift is an exact division
    assign s_reduced = m_sum[DIGIT] >> DIGIT;
    assign s_ge_m    = (s_reg >= m_ext);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            m_reg     <= '0;
            mp_reg    <= '0;
            s_reg     <= '0;
            cnt_reg   <= '0;
            p_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            m_reg     <= m_next;
            mp_reg    <= mp_next;
            s_reg     <= s_next;
            cnt_reg   <= cnt_next;
            p_reg     <= p_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        m_next     = m_reg;
        mp_next    = mp_reg;
        s_next     = s_reg;
        cnt_next   = cnt_reg;
        p_next     = p_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = A;
                    b_next     = B;
                    m_next     = M;
                    mp_next    = m_prime;
                    s_next     = '0;
                    cnt_next   = num_digits;
                    busy_next  = 1'b1;
                    state_next = (num_digits == '0) ? SUB : ADD_A;
                end
            end
            ADD_A: begin
                s_next     = a_sum[DIGIT];
                b_next     = b_reg >> DIGIT;
                state_next = ADD_M;
            end
            ADD_M: begin
                s_next     = s_reduced;
                cnt_next   = cnt_reg - 1'b1;
                state_next = (cnt_reg == CNT_W'(1)) ? SUB : ADD_A;
            end
            SUB: begin
                p_next     = s_ge_m ? WIDTH'(s_reg - m_ext) : s_reg[WIDTH-1:0];
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign P    = p_reg;
endmodule

// File: tb/tb_mon_prod_radix.sv
// Directed and randomised checks of mon_prod_radix at WIDTH=64 for DIGIT = 1, 2, 4.
// Expected results come from a product-then-halving reference, not an interleaved model.
module tb_mon_prod_radix;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_v [3];
    logic [63:0] a_v [3];
    logic [63:0] b_v [3];
    logic [63:0] m_v [3];
    logic [3:0]  mp_v [3];
    logic [9:0]  n_v [3];
    logic        busy_v [3];
    logic        done_v [3];
    logic [63:0] p_v [3];

    int total = 0;
    int bad   = 0;
    int cov_ge = 0;
    int cov_lt = 0;

    mon_prod_radix #(.WIDTH(64), .DIGIT(1), .CNT_W(10)) u_d1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .A(a_v[0]), .B(b_v[0]), .M(m_v[0]),
        .m_prime(mp_v[0][0:0]), .num_digits(n_v[0]), .busy(busy_v[0]), .done(done_v[0]), .P(p_v[0]));
    mon_prod_radix #(.WIDTH(64), .DIGIT(2), .CNT_W(10)) u_d2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .A(a_v[1]), .B(b_v[1]), .M(m_v[1]),
        .m_prime(mp_v[1][1:0]), .num_digits(n_v[1]), .busy(busy_v[1]), .done(done_v[1]), .P(p_v[1]));
    mon_prod_radix #(.WIDTH(64), .DIGIT(4), .CNT_W(10)) u_d4 (
        .clk(clk), .rst(rst), .start(start_v[2]), .A(a_v[2]), .B(b_v[2]), .M(m_v[2]),
        .m_prime(mp_v[2][3:0]), .num_digits(n_v[2]), .busy(busy_v[2]), .done(done_v[2]), .P(p_v[2]));

    // Observe which branch the final subtraction takes
    always @(posedge clk) begin
        if (u_d1.state_reg == 2'd3) begin if (u_d1.s_ge_m) cov_ge++; else cov_lt++; end
        if (u_d2.state_reg == 2'd3) begin if (u_d2.s_ge_m) cov_ge++; else cov_lt++; end
        if (u_d4.state_reg == 2'd3) begin if (u_d4.s_ge_m) cov_ge++; else cov_lt++; end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mont_ref(input logic [63:0] a, b, m, input int rbits);
        logic [127:0] t;
        logic [64:0]  x;
        t = ({64'd0, a} * {64'd0, b}) % {64'd0, m};
        x = {1'b0, t[63:0]};
        for (int i = 0; i < rbits; i++)
            x = x[0] ? ((x + {1'b0, m}) >> 1) : (x >> 1);
        return x[63:0];
    endfunction

    function automatic logic [3:0] mprime_of(input logic [63:0] m, input int d);
        logic [3:0] mask;
        logic [3:0] prod;
        mask = 4'((1 << d) - 1);
        for (int x = 0; x < 16; x++) begin
            prod = 4'(m[3:0] * 4'(x)) & mask;
            if (prod == mask && (4'(x) & mask) == 4'(x)) return 4'(x);
        end
        return 4'd0;
    endfunction

    task automatic run_op(input int k, input logic [63:0] a, b, m, input logic [3:0] mp,
                          input logic [9:0] n, input logic [63:0] exp_p, input string tag);
        int lat;
        logic busy_ok;
        @(negedge clk);
        start_v[k] = 1'b1; a_v[k] = a; b_v[k] = b; m_v[k] = m; mp_v[k] = mp; n_v[k] = n;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        a_v[k] = ~a; b_v[k] = ~b; m_v[k] = m ^ 64'hF0; mp_v[k] = ~mp; n_v[k] = ~n;
        lat = 0;
        busy_ok = 1'b1;
        while (!done_v[k] && lat < 400) begin
            if (!busy_v[k]) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_done_seen"}, 64'(done_v[k]), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(2 * int'(n) + 1));
        check({tag, "_P"}, p_v[k], exp_p);
        check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy_v[k]), 64'd0);
        $display("op %s: k=%0d n=%0d lat=%0d P=%0h exp=%0h", tag, k, n, lat, p_v[k], exp_p);
    endtask

    task automatic run_random(input int k, input int d, input int count);
        logic [63:0] m, a, b, e;
        for (int i = 0; i < count; i++) begin
            m = {$urandom, $urandom} | 64'd1;
            if (m < 64'd3) m = 64'd3;
            a = {$urandom, $urandom} % m;
            b = {$urandom, $urandom} % m;
            e = mont_ref(a, b, m, 64);
            run_op(k, a, b, m, mprime_of(m, d), 10'(64 / d), e, $sformatf("rnd_d%0d_%0d", d, i));
        end
    endtask

    initial begin
        int dones;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0; m_v[k] = '0; mp_v[k] = '0; n_v[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_busy%0d", k), 64'(busy_v[k]), 64'd0);
            check($sformatf("reset_done%0d", k), 64'(done_v[k]), 64'd0);
            check($sformatf("reset_P%0d", k), p_v[k], 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Hand-computed cases with M=13
        run_op(0, 64'd5, 64'd7,  64'd13, 4'd1, 10'd8, 64'd1, "d1_n8");
        run_op(1, 64'd5, 64'd7,  64'd13, 4'd3, 10'd4, 64'd1, "d2_n4");
        run_op(0, 64'd5, 64'd7,  64'd13, 4'd1, 10'd4, 64'd3, "d1_n4");
        run_op(0, 64'd0, 64'd12, 64'd13, 4'd1, 10'd4, 64'd0, "d1_a0");
        run_op(0, 64'd5, 64'd7,  64'd13, 4'd1, 10'd0, 64'd0, "d1_n0");
        run_op(0, 64'd5, 64'd7,  64'd13, 4'd1, 10'd8, 64'd1, "d1_restore");

        // start held while busy, operands scrambled mid-run
        @(negedge clk);
        start_v[0] = 1'b1; a_v[0] = 64'd5; b_v[0] = 64'd7; m_v[0] = 64'd13; mp_v[0] = 4'd1; n_v[0] = 10'd8;
        @(posedge clk);
        dones = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done_v[0]) dones++;
            start_v[0] = busy_v[0];
            a_v[0] = {$urandom, $urandom}; b_v[0] = {$urandom, $urandom}; m_v[0] = {$urandom, $urandom};
        end
        start_v[0] = 1'b0;
        check("busy_start_dones", 64'(dones), 64'd1);
        check("busy_start_P", p_v[0], 64'd1);
        $display("op busy_start: dones=%0d P=%0h", dones, p_v[0]);

        // Reset mid-operation
        @(negedge clk);
        run_op(1, 64'd6, 64'd9, 64'd13, 4'd3, 10'd4, mont_ref(64'd6, 64'd9, 64'd13, 8), "d2_pre_rst");
        @(negedge clk);
        start_v[0] = 1'b1; a_v[0] = 64'd5; b_v[0] = 64'd7; m_v[0] = 64'd13; mp_v[0] = 4'd1; n_v[0] = 10'd8;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", 64'(busy_v[0]), 64'd0);
        check("rst_done", 64'(done_v[0]), 64'd0);
        check("rst_P", p_v[0], 64'd0);
        check("rst_P_d2", p_v[1], 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done_v[0]) dones++;
        end
        check("rst_no_done", 64'(dones), 64'd0);
        $display("op rst_abandon: dones=%0d", dones);
        run_op(0, 64'd5, 64'd7, 64'd13, 4'd1, 10'd8, 64'd1, "d1_after_rst");

        cov_ge = 0;
        cov_lt = 0;
        fork
            run_random(0, 1, 334);
            run_random(1, 2, 333);
            run_random(2, 4, 333);
        join
        check("cov_sub_ge", 64'(cov_ge > 0), 64'd1);
        check("cov_sub_lt", 64'(cov_lt > 0), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
